ara_perf_sequencer: RTL and testbench

Measurement-window controller for the Ara SoC test harness. It opens and closes cycle-accurate measurement windows from the software counter-enable bit. Inside each window it counts runtime and CVA6 stall events, and latches the results into buffers with a valid/ready handshake. It also sequences end-of-test: an open window is closed and latched before exit is reported, so the bench never samples half-updated counters.

---
 rtl/ara_perf_pkg.sv | 23 ++
 rtl/ara_perf_sat_cnt.sv | 33 +++
 rtl/ara_perf_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_ara_perf_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ara_perf_pkg.sv
// ara_perf_pkg
// Shared types and constants for the Ara measurement-window sequencer.
// Provides:
//   perf_state_e  - sequencer FSM states (IDLE/RUN/DONE)
//   perf_cnt_t    - counter type at the default counter width
//   ExitBitIdx    - bit of the exit word that requests end-of-test
//   ExitCodeWidth - width of the exit code carried above the request bit
package ara_perf_pkg;

  localparam int unsigned CntWidthDefault = 64;
  localparam int unsigned ExitWordWidth   = 64;
  localparam int unsigned ExitBitIdx      = 0;
  localparam int unsigned ExitCodeWidth   = ExitWordWidth - 1;

  typedef logic [CntWidthDefault-1:0] perf_cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } perf_state_e;

endpackage

// File: rtl/ara_perf_sat_cnt.sv
// ara_perf_sat_cnt
// One saturating event counter used for the live window counters.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset, clears the count
//   load     - start of a window: count takes load_val (0 or 1)
//   load_val - first-cycle event bit
//   inc      - add one this cycle (ignored while load is high)
//   value    - current count, sticks at all-ones
module ara_perf_sat_cnt #(
  parameter int unsigned Width = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             load_val,
  input  logic             inc,
  output logic [Width-1:0] value
);

  // Load wins over increment so a new window always starts from its first
  // sample; once all-ones is reached further increments are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= Width'(load_val);
    end else if (inc && (value != '1)) begin
      value <= value + Width'(1);
    end
  end

endmodule

// File: rtl/ara_perf_sequencer.sv
// ara_perf_sequencer
// Measurement-window controller. A window opens when the software enable
// rises and closes when it falls; while open it counts cycles and (optionally)
// CVA6 stall events. On close the live counts are copied into result buffers
// guarded by a valid/ready handshake. An exit request closes any open window,
// latches it, and parks the block in DONE so the results stay stable.
//
// Optional feature macro: ARA_PERF_STALL_CNT_EN
//   defined   - D$, I$ and scoreboard-full counters are built
//   undefined - stall inputs unused, stall result outputs tied to 0
//
// Ports:
//   clk_i, rst_i             - clock, synchronous active-high reset
//   hw_cnt_en_i              - measurement enable level
//   dcache_stall_i           - D$ stall event per cycle
//   icache_stall_i           - I$ stall event per cycle
//   sb_full_i                - scoreboard-full event per cycle
//   exit_i                   - bit0 exit request, bits 63:1 exit code
//   result_ready_i           - consumer accepts latched results
//   result_valid_o           - latched results available
//   runtime_o                - latched cycle count
//   dcache_stall_o           - latched D$ stall count
//   icache_stall_o           - latched I$ stall count
//   sb_full_o                - latched scoreboard-full count
//   win_cnt_o                - number of closed windows (wraps)
//   overflow_o               - sticky: a result was overwritten unaccepted
//   dump_en_o                - high while a window is open
//   exit_valid_o             - exit sequencing complete
//   exit_code_o              - captured exit code
module ara_perf_sequencer
  import ara_perf_pkg::*;
#(
  parameter int unsigned CntWidth    = 64,
  parameter int unsigned WinCntWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     hw_cnt_en_i,
  input  logic                     dcache_stall_i,
  input  logic                     icache_stall_i,
  input  logic                     sb_full_i,
  input  logic [ExitWordWidth-1:0] exit_i,
  input  logic                     result_ready_i,
  output logic                     result_valid_o,
  output logic [CntWidth-1:0]      runtime_o,
  output logic [CntWidth-1:0]      dcache_stall_o,
  output logic [CntWidth-1:0]      icache_stall_o,
  output logic [CntWidth-1:0]      sb_full_o,
  output logic [WinCntWidth-1:0]   win_cnt_o,
  output logic                     overflow_o,
  output logic                     dump_en_o,
  output logic                     exit_valid_o,
  output logic [ExitCodeWidth-1:0] exit_code_o
);

  perf_state_e state_q, state_d;

  logic exit_req;
  logic cnt_load;
  logic cnt_inc;
  logic do_latch;
  logic do_exit;

  logic [CntWidth-1:0] runtime_live;

  assign exit_req = exit_i[ExitBitIdx];

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle control. Exit is checked before the enable in
  // every state so an end-of-test request can never be swallowed by a window
  // opening or continuing. Closing and exit cycles are not counted.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    do_latch = 1'b0;
    do_exit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (exit_req) begin
          state_d = DONE;
          do_exit = 1'b1;
        end else if (hw_cnt_en_i) begin
          state_d  = RUN;
          cnt_load = 1'b1;
        end
      end
      RUN: begin
        if (exit_req) begin
          state_d  = DONE;
          do_exit  = 1'b1;
          do_latch = 1'b1;
        end else if (!hw_cnt_en_i) begin
          state_d  = IDLE;
          do_latch = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  ara_perf_sat_cnt #(
    .Width(CntWidth)
  ) u_runtime_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (cnt_load),
    .load_val (1'b1),
    .inc      (cnt_inc),
    .value    (runtime_live)
  );

  // Handshake, window bookkeeping and exit capture. A close that coincides
  // with acceptance keeps valid high for the new data and is not an
  // overflow, because the old result was consumed on that same edge. Once in
  // DONE the ready input is ignored so the final results remain presented.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_valid_o <= 1'b0;
      runtime_o      <= '0;
      win_cnt_o      <= '0;
      overflow_o     <= 1'b0;
      dump_en_o      <= 1'b0;
      exit_valid_o   <= 1'b0;
      exit_code_o    <= '0;
    end else begin
      dump_en_o <= (state_d == RUN);
      if (do_exit) begin
        exit_valid_o <= 1'b1;
        exit_code_o  <= exit_i[ExitWordWidth-1:ExitBitIdx+1];
      end
      if (do_latch) begin
        runtime_o      <= runtime_live;
        win_cnt_o      <= win_cnt_o + WinCntWidth'(1);
        result_valid_o <= 1'b1;
        if (result_valid_o && !result_ready_i) begin
          overflow_o <= 1'b1;
        end
      end else if ((state_q != DONE) && result_valid_o && result_ready_i) begin
        result_valid_o <= 1'b0;
      end
    end
  end

`ifdef ARA_PERF_STALL_CNT_EN
  logic [CntWidth-1:0] dcache_live;
  logic [CntWidth-1:0] icache_live;
  logic [CntWidth-1:0] sb_full_live;

  ara_perf_sat_cnt #(
    .Width(CntWidth)
  ) u_dcache_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (cnt_load),
    .load_val (dcache_stall_i),
    .inc      (cnt_inc & dcache_stall_i),
    .value    (dcache_live)
  );

  ara_perf_sat_cnt #(
    .Width(CntWidth)
  ) u_icache_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (cnt_load),
    .load_val (icache_stall_i),
    .inc      (cnt_inc & icache_stall_i),
    .value    (icache_live)
  );

  ara_perf_sat_cnt #(
    .Width(CntWidth)
  ) u_sb_full_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (cnt_load),
    .load_val (sb_full_i),
    .inc      (cnt_inc & sb_full_i),
    .value    (sb_full_live)
  );

  // Stall result buffers follow the same latch strobe as runtime.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dcache_stall_o <= '0;
      icache_stall_o <= '0;
      sb_full_o      <= '0;
    end else if (do_latch) begin
      dcache_stall_o <= dcache_live;
      icache_stall_o <= icache_live;
      sb_full_o      <= sb_full_live;
    end
  end
`else
  logic unused_stall_inputs;

  assign unused_stall_inputs = dcache_stall_i ^ icache_stall_i ^ sb_full_i;
  assign dcache_stall_o      = '0;
  assign icache_stall_o      = '0;
  assign sb_full_o           = '0;
`endif

endmodule

// File: tb/tb_ara_perf_sequencer.sv
// tb_ara_perf_sequencer
// Directed bench for ara_perf_sequencer. A second instance with CntWidth=4
// shares the stimulus so counter saturation can be observed. Stall-count
// expectations follow ARA_PERF_STALL_CNT_EN.
module tb_ara_perf_sequencer;

`ifdef ARA_PERF_STALL_CNT_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hw_cnt_en = 1'b0;
  logic        dcache_stall = 1'b0;
  logic        icache_stall = 1'b0;
  logic        sb_full = 1'b0;
  logic [63:0] exit_word = '0;
  logic        result_ready = 1'b0;

  logic        result_valid;
  logic [63:0] runtime;
  logic [63:0] dcache_cnt;
  logic [63:0] icache_cnt;
  logic [63:0] sb_full_cnt;
  logic [7:0]  win_cnt;
  logic        overflow;
  logic        dump_en;
  logic        exit_valid;
  logic [62:0] exit_code;

  logic        s_result_valid;
  logic [3:0]  s_runtime;
  logic [3:0]  s_dcache_cnt;
  logic [3:0]  s_icache_cnt;
  logic [3:0]  s_sb_full_cnt;
  logic [7:0]  s_win_cnt;
  logic        s_overflow;
  logic        s_dump_en;
  logic        s_exit_valid;
  logic [62:0] s_exit_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ara_perf_sequencer #(
    .CntWidth    (64),
    .WinCntWidth (8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .hw_cnt_en_i    (hw_cnt_en),
    .dcache_stall_i (dcache_stall),
    .icache_stall_i (icache_stall),
    .sb_full_i      (sb_full),
    .exit_i         (exit_word),
    .result_ready_i (result_ready),
    .result_valid_o (result_valid),
    .runtime_o      (runtime),
    .dcache_stall_o (dcache_cnt),
    .icache_stall_o (icache_cnt),
    .sb_full_o      (sb_full_cnt),
    .win_cnt_o      (win_cnt),
    .overflow_o     (overflow),
    .dump_en_o      (dump_en),
    .exit_valid_o   (exit_valid),
    .exit_code_o    (exit_code)
  );

  ara_perf_sequencer #(
    .CntWidth    (4),
    .WinCntWidth (8)
  ) dut_sat (
    .clk_i          (clk),
    .rst_i          (rst),
    .hw_cnt_en_i    (hw_cnt_en),
    .dcache_stall_i (dcache_stall),
    .icache_stall_i (icache_stall),
    .sb_full_i      (sb_full),
    .exit_i         (exit_word),
    .result_ready_i (result_ready),
    .result_valid_o (s_result_valid),
    .runtime_o      (s_runtime),
    .dcache_stall_o (s_dcache_cnt),
    .icache_stall_o (s_icache_cnt),
    .sb_full_o      (s_sb_full_cnt),
    .win_cnt_o      (s_win_cnt),
    .overflow_o     (s_overflow),
    .dump_en_o      (s_dump_en),
    .exit_valid_o   (s_exit_valid),
    .exit_code_o    (s_exit_code)
  );

  // Drive one cycle of inputs, let the DUT sample them, then settle.
  task automatic applyStimulus(input logic en, input logic dst,
                               input logic [63:0] ex, input logic rdy);
    hw_cnt_en    = en;
    dcache_stall = dst;
    exit_word    = ex;
    result_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b0);
    rst = 1'b0;
  endtask

  // Hold enable for n cycles with ready low, then close with the given ready.
  task automatic runWindow(input int n, input logic close_rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 64'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'd0, close_rdy);
  endtask

  initial begin
    // Reset state.
    doReset();
    checkOutput("rst_valid", result_valid, 0);
    checkOutput("rst_runtime", runtime, 0);
    checkOutput("rst_win", win_cnt, 0);
    checkOutput("rst_dump", dump_en, 0);
    checkOutput("rst_exit_valid", exit_valid, 0);
    checkOutput("rst_overflow", overflow, 0);

    // 100-cycle window, D$ stall on 7 cycles, scoreboard full throughout.
    sb_full = 1'b1;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, (i % 10 == 5) && (i < 70), 64'd0, 1'b0);
      if (i == 0)  checkOutput("w1_dump_rise", dump_en, 1);
      if (i == 99) checkOutput("w1_valid_before_close", result_valid, 0);
    end
    sb_full = 1'b0;
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b0);
    checkOutput("w1_valid", result_valid, 1);
    checkOutput("w1_runtime", runtime, 100);
    checkOutput("w1_dcache", dcache_cnt, StallEn ? 64'd7 : 64'd0);
    checkOutput("w1_sb_full", sb_full_cnt, StallEn ? 64'd100 : 64'd0);
    checkOutput("w1_icache", icache_cnt, 0);
    checkOutput("w1_win", win_cnt, 1);
    checkOutput("w1_dump_fall", dump_en, 0);
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b1);
    checkOutput("w1_accept", result_valid, 0);

    // Close coinciding with acceptance keeps valid without overflow.
    runWindow(5, 1'b0);
    checkOutput("w5_valid", result_valid, 1);
    runWindow(6, 1'b1);
    checkOutput("w6_valid", result_valid, 1);
    checkOutput("w6_runtime", runtime, 6);
    checkOutput("w6_no_overflow", overflow, 0);
    checkOutput("w6_win", win_cnt, 3);

    // Two unaccepted windows overflow and overwrite.
    doReset();
    runWindow(10, 1'b0);
    checkOutput("w10_runtime", runtime, 10);
    checkOutput("w10_overflow", overflow, 0);
    runWindow(20, 1'b0);
    checkOutput("w20_runtime", runtime, 20);
    checkOutput("w20_overflow", overflow, 1);
    checkOutput("w20_win", win_cnt, 2);
    checkOutput("w20_valid", result_valid, 1);
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b1);
    checkOutput("w20_accept", result_valid, 0);
    checkOutput("w20_overflow_sticky", overflow, 1);

    // Exit during RUN at window cycle 50.
    doReset();
    for (int i = 0; i < 49; i++) applyStimulus(1'b1, 1'b0, 64'd0, 1'b0);
    checkOutput("ex_valid_before", result_valid, 0);
    checkOutput("ex_exit_before", exit_valid, 0);
    applyStimulus(1'b1, 1'b0, 64'h0000_0000_0000_0007, 1'b0);
    checkOutput("ex_runtime", runtime, 49);
    checkOutput("ex_code", exit_code, 3);
    checkOutput("ex_exit_valid", exit_valid, 1);
    checkOutput("ex_result_valid", result_valid, 1);
    checkOutput("ex_dump", dump_en, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 64'd0, 1'b1);
    checkOutput("ex_done_runtime", runtime, 49);
    checkOutput("ex_done_exit", exit_valid, 1);
    checkOutput("ex_done_dump", dump_en, 0);

    // Exit in IDLE beats enable.
    doReset();
    applyStimulus(1'b1, 1'b0, 64'd1, 1'b0);
    checkOutput("ix_exit_valid", exit_valid, 1);
    checkOutput("ix_code", exit_code, 0);
    checkOutput("ix_result_valid", result_valid, 0);
    checkOutput("ix_dump", dump_en, 0);
    runWindow(3, 1'b0);
    checkOutput("ix_done_runtime", runtime, 0);
    checkOutput("ix_done_valid", result_valid, 0);

    // Saturation of the 4-bit instance over 20 cycles.
    doReset();
    runWindow(20, 1'b0);
    checkOutput("sat_runtime4", s_runtime, 15);
    checkOutput("sat_runtime64", runtime, 20);

    // Reset mid-window discards live counts and prior results.
    doReset();
    runWindow(3, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 64'd0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 64'd0, 1'b0);
    rst = 1'b0;
    checkOutput("mr_runtime", runtime, 0);
    checkOutput("mr_valid", result_valid, 0);
    checkOutput("mr_win", win_cnt, 0);
    checkOutput("mr_dump", dump_en, 0);
    runWindow(5, 1'b0);
    checkOutput("mr_runtime5", runtime, 5);
    checkOutput("mr_win1", win_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
